// File: rtl/sram_port_loader.sv
// Write-side master for one port of a dual-port RAM: fills the whole RAM with a
// constant, or packs a byte stream little-endian into words at consecutive addresses.
//
// state   | meaning
// S_IDLE  | waiting for clear_start_i / load_start_i
// S_CLEAR | writing the latched fill value to every address
// S_LOAD  | accepting bytes, writing each completed word
// S_FIN   | final load strobe on the bus, done pulse follows
module sram_port_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  clear_start_i,
  input  logic [DATA_WIDTH-1:0] fill_value_i,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic                  dl_valid_i,
  input  logic [7:0]            dl_data_i,
  input  logic                  dl_last_i,
  output logic                  dl_ready_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_cen_o,
  output logic                  ram_we_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wrapped_o
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_FIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [1:0]            idx_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  dl_ready_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  ram_cen_q;
  logic                  ram_we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wrapped_q;
  logic                  accept;
  logic                  word_done;

  // Buffer is zeroed after every write, so a short final word is already padded.
  always_comb begin
    word_d = buf_q;
    for (int b = 0; b < BYTES; b++) begin
      if (idx_q == 2'(b)) word_d[b*8 +: 8] = dl_data_i;
    end
  end

  assign accept    = dl_valid_i && dl_ready_q;
  assign word_done = dl_last_i || (idx_q == LAST_IDX);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      fill_q     <= '0;
      dl_ready_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_cen_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      ram_cen_q <= 1'b0;
      ram_we_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_start_i) begin
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            fill_q     <= fill_value_i;
            ram_cen_q  <= 1'b1;
            ram_we_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= fill_value_i;
            cnt_q      <= ADDR_WIDTH'(1);
          end else if (load_start_i) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            dl_ready_q <= 1'b1;
            cnt_q      <= load_base_i;
            idx_q      <= '0;
            buf_q      <= '0;
            wrapped_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ram_cen_q  <= 1'b1;
            ram_we_q   <= 1'b1;
            ram_addr_q <= cnt_q;
            ram_data_q <= fill_q;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (word_done) begin
              ram_cen_q  <= 1'b1;
              ram_we_q   <= 1'b1;
              ram_addr_q <= cnt_q;
              ram_data_q <= word_d;
              cnt_q      <= cnt_q + 1'b1;
              if (cnt_q == '1) wrapped_q <= 1'b1;
              idx_q      <= '0;
              buf_q      <= '0;
              if (dl_last_i) begin
                state_q    <= S_FIN;
                dl_ready_q <= 1'b0;
              end
            end else begin
              buf_q <= word_d;
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dl_ready_o = dl_ready_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_cen_o  = ram_cen_q;
  assign ram_we_o   = ram_we_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wrapped_o  = wrapped_q;

endmodule

// File: tb/tb_sram_port_loader.sv
// Bench for sram_port_loader: per-cycle expected outputs are scheduled from the
// stimulus (word index, packing, done timing) and compared every cycle.
module tb_sram_port_loader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int N = 4096;

  logic          clk;
  logic          resetn;
  logic          clear_start;
  logic [DW-1:0] fill_value;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          dl_valid;
  logic [7:0]    dl_data;
  logic          dl_last;
  logic          dl_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_cen;
  logic          ram_we;
  logic          busy;
  logic          done;
  logic          wrapped;

  sram_port_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .resetn_i(resetn), .clear_start_i(clear_start), .fill_value_i(fill_value),
    .load_start_i(load_start), .load_base_i(load_base), .dl_valid_i(dl_valid),
    .dl_data_i(dl_data), .dl_last_i(dl_last), .dl_ready_o(dl_ready), .ram_addr_o(ram_addr),
    .ram_data_o(ram_data), .ram_cen_o(ram_cen), .ram_we_o(ram_we), .busy_o(busy),
    .done_o(done), .wrapped_o(wrapped)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit            exp_busy[N];
  bit            exp_ready[N];
  bit            exp_done[N];
  bit            exp_cen[N];
  bit            exp_wrap[N];
  logic [AW-1:0] exp_addr[N];
  logic [DW-1:0] exp_data[N];

  typedef struct {int a; int d;} wr_t;
  wr_t wlog[$];

  int         ld_base;
  int         ld_k;
  logic [7:0] ld_bytes[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      chk("busy", busy, exp_busy[cyc]);
      chk("dl_ready", dl_ready, exp_ready[cyc]);
      chk("done", done, exp_done[cyc]);
      chk("ram_cen", ram_cen, exp_cen[cyc]);
      chk("ram_we", ram_we, exp_cen[cyc]);
      chk("wrapped", wrapped, exp_wrap[cyc]);
      if (exp_cen[cyc]) begin
        chk("ram_addr", ram_addr, exp_addr[cyc]);
        chk("ram_data", ram_data, exp_data[cyc]);
      end
    end
    if (ram_cen) wlog.push_back('{int'(ram_addr), int'(ram_data)});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic void fwd_busy(int from, bit v);
    for (int i = from; i < N; i++) exp_busy[i] = v;
  endfunction

  function automatic void fwd_ready(int from, bit v);
    for (int i = from; i < N; i++) exp_ready[i] = v;
  endfunction

  function automatic void fwd_wrap(int from, bit v);
    for (int i = from; i < N; i++) exp_wrap[i] = v;
  endfunction

  function automatic void model_reset(int from);
    for (int i = from; i < N; i++) begin
      exp_busy[i] = 0; exp_ready[i] = 0; exp_done[i] = 0;
      exp_cen[i] = 0; exp_wrap[i] = 0;
    end
  endfunction

  task automatic chk_wr(input string name, input int idx, input int a, input int d);
    if (idx < wlog.size()) begin
      chk({name, "_addr"}, wlog[idx].a, a);
      chk({name, "_data"}, wlog[idx].d, d);
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  task automatic start_load(input int base);
    int s;
    load_start = 1'b1;
    load_base  = AW'(base);
    dl_valid   = 1'($urandom_range(0, 1));
    dl_data    = 8'($urandom);
    dl_last    = 1'($urandom_range(0, 1));
    s = cyc + 1;
    fwd_busy(s, 1);
    fwd_ready(s, 1);
    fwd_wrap(s, 0);
    ld_base = base;
    ld_k = 0;
    tick();
    load_start = 1'b0;
    dl_valid = 1'b0;
    dl_last = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int b, pos, a;
    logic [15:0] w;
    b = cyc;
    pos = ld_k % 2;
    ld_bytes[pos] = d;
    dl_valid = 1'b1;
    dl_data = d;
    dl_last = last;
    if (pos == 1 || last) begin
      w = {8'h00, ld_bytes[0]};
      if (pos == 1) w[15:8] = ld_bytes[1];
      a = (ld_base + ld_k / 2) % DEPTH;
      exp_cen[b+1] = 1;
      exp_addr[b+1] = AW'(a);
      exp_data[b+1] = w;
      if (a == DEPTH - 1) fwd_wrap(b + 1, 1);
    end
    ld_k++;
    if (last) begin
      fwd_ready(b + 1, 0);
      fwd_busy(b + 2, 0);
      exp_done[b+2] = 1;
    end
    tick();
    dl_valid = 1'b0;
    dl_last = 1'b0;
  endtask

  task automatic load_gap();
    dl_valid = 1'b0;
    dl_data = 8'($urandom);
    dl_last = 1'($urandom_range(0, 1));
    tick();
    dl_last = 1'b0;
  endtask

  task automatic idle_junk();
    dl_valid = 1'($urandom_range(0, 1));
    dl_data = 8'($urandom);
    dl_last = 1'($urandom_range(0, 1));
    tick();
    dl_valid = 1'b0;
    dl_last = 1'b0;
  endtask

  task automatic start_clear(input logic [15:0] fv, input bit wl, input logic [3:0] lb, input int ia);
    int s;
    clear_start = 1'b1;
    fill_value = fv;
    load_start = wl;
    load_base = lb;
    s = cyc + 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_cen[s+i] = 1;
      exp_addr[s+i] = AW'(i);
      exp_data[s+i] = fv;
      exp_busy[s+i] = 1;
    end
    exp_done[s+DEPTH] = 1;
    tick();
    clear_start = 1'b0;
    load_start = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      fill_value = DW'($urandom);
      load_start = (i == ia);
      load_base = AW'($urandom);
      tick();
    end
    load_start = 1'b0;
  endtask

  initial begin
    int n0, len;
    logic [7:0] rb;
    resetn = 1'b1;
    clear_start = 1'b0; fill_value = '0; load_start = 1'b0; load_base = '0;
    dl_valid = 1'b0; dl_data = '0; dl_last = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) tick();
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_cen", ram_cen, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_ready", dl_ready, 0);
    resetn = 1'b1;
    repeat (2) tick();

    n0 = wlog.size();
    start_clear(16'hA55A, 0, 4'd0, -1);
    chk("clr_count", wlog.size() - n0, 16);
    for (int i = 0; i < DEPTH; i++) chk_wr("clr", n0 + i, i, 16'hA55A);

    n0 = wlog.size();
    start_clear(16'h1234, 1, 4'd5, -1);
    chk("conflict_count", wlog.size() - n0, 16);
    chk_wr("conflict_first", n0, 0, 16'h1234);
    n0 = wlog.size();
    start_clear(16'h0F0F, 0, 4'd0, 7);
    repeat (3) tick();
    chk("ign_count", wlog.size() - n0, 16);
    chk("ign_busy", busy, 0);
    chk("ign_ready", dl_ready, 0);

    n0 = wlog.size();
    start_load(3);
    send_byte(8'h11, 0); load_gap(); load_gap();
    send_byte(8'h22, 0); load_gap();
    send_byte(8'h33, 0); repeat (3) load_gap();
    send_byte(8'h44, 1);
    repeat (3) tick();
    chk("gap_count", wlog.size() - n0, 2);
    chk_wr("gap_w0", n0, 3, 16'h2211);
    chk_wr("gap_w1", n0 + 1, 4, 16'h4433);

    n0 = wlog.size();
    start_load(7);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
    repeat (3) tick();
    chk("odd_count", wlog.size() - n0, 2);
    chk_wr("odd_w0", n0, 7, 16'hBBAA);
    chk_wr("odd_w1", n0 + 1, 8, 16'h00CC);

    n0 = wlog.size();
    start_load(15);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
    repeat (3) tick();
    chk("wrap_count", wlog.size() - n0, 2);
    chk_wr("wrap_w0", n0, 15, 16'h0201);
    chk_wr("wrap_w1", n0 + 1, 0, 16'h0403);
    chk("wrap_flag", wrapped, 1);

    n0 = wlog.size();
    start_load(5);
    send_byte(8'h77, 0);
    resetn = 1'b0;
    model_reset(cyc + 1);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("rstmid_count", wlog.size() - n0, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_wrapped", wrapped, 0);
    start_load(9);
    send_byte(8'h12, 0); send_byte(8'h34, 1);
    repeat (3) tick();
    chk_wr("rstmid_next", n0, 9, 16'h3412);

    for (int t = 0; t < 30 && cyc < N - 200; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        start_clear(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1);
      end else begin
        start_load(int'($urandom_range(0, DEPTH - 1)));
        len = int'($urandom_range(1, 9));
        for (int i = 0; i < len; i++) begin
          repeat ($urandom_range(0, 2)) load_gap();
          rb = 8'($urandom);
          send_byte(rb, i == len - 1);
        end
      end
      repeat ($urandom_range(1, 3)) idle_junk();
    end

    repeat (2) tick();
    chk("cycle_budget", cyc < N - 4, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_loader.md
# sram_port_loader

Sequential write-side master for one port of a dual-port synchronous RAM: it either zero/pattern-fills the whole RAM or packs an incoming byte stream (ROM/NVRAM download from the HPS) into DATA_WIDTH-bit words and writes them at consecutive addresses. It sits between the download interface and the write port of a dual-port RAM. The other port stays free for the game logic to read.

## Interface
- DATA_WIDTH, 16, RAM word width; must be 8, 16 or 32.
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH.
- clk  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- clear_start  in  1  one-cycle pulse; starts a full-RAM fill with fill_value
- fill_value  in  DATA_WIDTH  word written during clear; sampled at clear_start
- load_start  in  1  one-cycle pulse; starts a stream load at load_base
- load_base  in  ADDR_WIDTH  first word address of the load; sampled at load_start
- dl_valid  in  1  byte-stream valid
- dl_data  in  8  byte-stream data
- dl_last  in  1  marks the final byte of the stream; qualified by dl_valid
- dl_ready  out  1  loader accepts a byte this cycle
- ram_addr  out  ADDR_WIDTH  RAM port address
- ram_data  out  DATA_WIDTH  RAM port write data
- ram_cen  out  1  RAM port enable
- ram_we  out  1  RAM port write enable
- busy  out  1  high in CLEAR or LOAD
- done  out  1  one-cycle pulse when an operation completes
- wrapped  out  1  sticky; a load ran past the top address and wrapped to 0

## Operation
- BYTES = DATA_WIDTH/8. Bytes pack little-endian: first byte of a word goes to bits [7:0].
- States: IDLE, CLEAR, LOAD.
- IDLE:
  - busy=0, dl_ready=0.
  - clear_start: go to CLEAR, counter=0, latch fill_value.
  - Otherwise load_start: go to LOAD, counter=load_base, byte index=0, clear wrapped.
  - clear_start and load_start in the same cycle: clear wins and the load is dropped.
- CLEAR:
  - Each cycle writes the latched fill_value to counter, then increments counter.
  - After writing address 2**ADDR_WIDTH-1: go to IDLE and pulse done.
  - dl_ready=0 throughout.
  - Start pulses are ignored while busy.
- LOAD:
  - dl_ready=1 every cycle; throughput is one byte per clock.
  - A byte is accepted when dl_valid && dl_ready. It shifts into the word buffer and the byte index increments.
  - When the accepted byte completes a word (index BYTES-1), the word is written at counter, counter increments, and the index returns to 0.
  - dl_last on an accepted byte with a partial word: the upper unfilled bytes are zero-padded and the word is written.
  - After the dl_last write: go to IDLE and pulse done.
  - dl_last on a byte that completes a word exactly: one write only, no extra padded word.
  - Counter increments modulo 2**ADDR_WIDTH. An increment from all-ones to 0 sets wrapped, which stays set until the next load_start or reset.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, partial word discarded, counter=0.
  - All outputs 0: ram_addr, ram_data, ram_cen, ram_we, busy, done, wrapped, dl_ready.

## Timing
- All outputs are registered.
- RAM write strobes: ram_cen=ram_we=1 for exactly one cycle per word, with ram_addr and ram_data valid in that same cycle. ram_cen=ram_we=0 at all other times.
- CLEAR:
  - First write strobe is the cycle after clear_start is sampled.
  - 2**ADDR_WIDTH consecutive strobe cycles.
  - done is high the cycle after the last strobe; busy falls in that same cycle.
- LOAD:
  - The write strobe appears the cycle after the word-completing (or last) byte is accepted.
  - done is high the cycle after the final strobe; busy falls in that same cycle.
  - dl_ready first goes high the cycle after load_start is sampled.
- The loader never reads the RAM. The write port issues no reads.

## Test plan
- Reset checks:
  - Hold resetn=0 → all outputs 0.
  - Assert resetn=0 mid-LOAD after 1 byte (DATA_WIDTH=16) → no strobe, busy=0, next load starts clean.
- Clear, ADDR_WIDTH=4, fill_value=16'hA55A → 16 strobes at addresses 0..15 on consecutive cycles, each with data A55A, then done pulse, busy=0.
- Load with gaps, DATA_WIDTH=16, load_base=3, bytes 11,22,33,44 (dl_last on 44) with dl_valid gaps inserted → writes 2211@3, 4433@4, then done.
- Odd-length load, 3 bytes AA,BB,CC (dl_last on CC) → writes BBAA@base, 00CC@base+1, exactly 2 strobes.
- Wrap, ADDR_WIDTH=4, load_base=15, 4 bytes → writes at 15 then 0, wrapped=1 after the second write.
- Start conflicts: clear_start and load_start in the same cycle → CLEAR runs. load_start issued during CLEAR → ignored, no LOAD follows.
